// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage; issues data-memory loads/stores, aligns/extends load data, registers MEM/WB.
// Latency: 1 cycle for zero-wait accesses and non-memory ops; N+1 cycles when memory holds dmem_ready low for N cycles.
// Backpressure: stall is raised combinationally while a request is outstanding and dmem_ready is low; MEM/WB holds while stalled.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  // EX/MEM register contents
  input  logic        ex_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic        reg_write,
  input  logic [4:0]  rd,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  // data memory port
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  // pipeline control / exception
  output logic        stall,
  output logic        misaligned,
  // MEM-stage forwarding source
  output logic        mem_reg_write,
  output logic [4:0]  mem_rd,
  output logic [31:0] mem_forward_value,
  // MEM/WB register
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic        w_acc;
  logic        w_illegal;
  logic        w_misal;
  logic        w_bad;
  logic        w_req;
  logic        w_stall;
  logic [1:0]  w_lane;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_rbyte;
  logic [15:0] w_rhalf;
  logic [31:0] w_load_data;
  logic        w_is_load;

  logic        r_wb_reg_write;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_misaligned;

  assign w_lane    = alu_result[1:0];
  assign w_acc     = ex_valid & (mem_read | mem_write);
  assign w_is_load = ex_valid & mem_read;

  // Classify the access: unsupported width encodings and unaligned H/W are rejected before any request.
  always_comb begin
    w_illegal = 1'b0;
    w_misal   = 1'b0;
    case (funct3)
      3'b000, 3'b100: w_misal = 1'b0;
      3'b001, 3'b101: w_misal = w_lane[0];
      3'b010:         w_misal = (w_lane != 2'b00);
      default:        w_illegal = 1'b1;
    endcase
  end

  // A bad access only matters when there is actually a memory op in flight.
  assign w_bad = w_acc & (w_misal | w_illegal);

  // Next-state and request generation; WAIT keeps the request up because inputs are frozen upstream.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req = w_acc & ~w_bad;
        if (w_req && !dmem_ready) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        w_req = 1'b1;
        if (dmem_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_req       = 1'b0;
      end
    endcase
  end

  // FSM state register; reset abandons any outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request and stall are gated by rst so they drop the moment reset asserts, not at the next edge.
  assign dmem_req = w_req & ~rst;
  assign w_stall  = w_req & ~dmem_ready & ~rst;
  assign stall    = w_stall;

  // Store lane steering: data is replicated across lanes, byte enables pick the target lane(s).
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = write_data;
    if (mem_write) begin
      case (funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << w_lane;
          w_wdata = {4{write_data[7:0]}};
        end
        2'b01: begin
          w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{write_data[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = write_data;
        end
      endcase
    end
  end

  assign dmem_we    = w_req & mem_write & ~rst;
  assign dmem_addr  = {alu_result[31:2], 2'b00};
  assign dmem_wdata = w_wdata;
  assign dmem_be    = w_be;

  // Load lane extraction and sign/zero extension.
  always_comb begin
    w_rbyte = dmem_rdata[7:0];
    case (w_lane)
      2'b00:   w_rbyte = dmem_rdata[7:0];
      2'b01:   w_rbyte = dmem_rdata[15:8];
      2'b10:   w_rbyte = dmem_rdata[23:16];
      default: w_rbyte = dmem_rdata[31:24];
    endcase
    w_rhalf = w_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3)
      3'b000:  w_load_data = {{24{w_rbyte[7]}}, w_rbyte};
      3'b100:  w_load_data = {24'h000000, w_rbyte};
      3'b001:  w_load_data = {{16{w_rhalf[15]}}, w_rhalf};
      3'b101:  w_load_data = {16'h0000, w_rhalf};
      default: w_load_data = dmem_rdata;
    endcase
  end

  // MEM/WB register and exception pulse; both freeze while the stage is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_reg_write <= 1'b0;
      r_wb_rd        <= 5'd0;
      r_wb_data      <= 32'd0;
      r_misaligned   <= 1'b0;
    end else if (!w_stall) begin
      r_wb_reg_write <= ex_valid & reg_write & ~w_bad;
      r_wb_rd        <= rd;
      r_wb_data      <= w_is_load ? w_load_data : alu_result;
      r_misaligned   <= w_bad;
    end
  end

  assign wb_reg_write = r_wb_reg_write;
  assign wb_rd        = r_wb_rd;
  assign wb_data      = r_wb_data;
  assign misaligned   = r_misaligned;

  // Loads are excluded from MEM forwarding; the hazard unit bubbles load-use instead.
  assign mem_reg_write     = ex_valid & reg_write & ~mem_read;
  assign mem_rd            = rd;
  assign mem_forward_value = alu_result;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
// Inputs change on the falling edge; combinational outputs are sampled 1ns later, registered outputs 1ns after the rising edge.
// Each scenario task carries its own inline comparisons.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic        reg_write;
  logic [4:0]  rd;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic        misaligned;
  logic        mem_reg_write;
  logic [4:0]  mem_rd;
  logic [31:0] mem_forward_value;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int pass_cnt  = 0;
  int total_cnt = 0;

  mem_stage dut (
    .clk               (clk),
    .rst               (rst),
    .ex_valid          (ex_valid),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .funct3            (funct3),
    .reg_write         (reg_write),
    .rd                (rd),
    .alu_result        (alu_result),
    .write_data        (write_data),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_be           (dmem_be),
    .dmem_ready        (dmem_ready),
    .dmem_rdata        (dmem_rdata),
    .stall             (stall),
    .misaligned        (misaligned),
    .mem_reg_write     (mem_reg_write),
    .mem_rd            (mem_rd),
    .mem_forward_value (mem_forward_value),
    .wb_reg_write      (wb_reg_write),
    .wb_rd             (wb_rd),
    .wb_data           (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one EX/MEM instruction plus the memory response at the falling edge.
  task automatic set_inst(input logic v, input logic rdm, input logic wrm, input logic [2:0] f3,
                          input logic rw, input logic [4:0] r, input logic [31:0] a,
                          input logic [31:0] wd, input logic rdy, input logic [31:0] rdat);
    @(negedge clk);
    ex_valid   = v;
    mem_read   = rdm;
    mem_write  = wrm;
    funct3     = f3;
    reg_write  = rw;
    rd         = r;
    alu_result = a;
    write_data = wd;
    dmem_ready = rdy;
    dmem_rdata = rdat;
    #1;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ex_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
    reg_write = 1'b0; rd = 5'd0; alu_result = 32'd0; write_data = 32'd0;
    dmem_ready = 1'b0; dmem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (wb_reg_write !== 1'b0) $display("FAIL reset_wb_reg_write got %b exp 0", wb_reg_write); else pass_cnt++;
    total_cnt++; if (wb_rd !== 5'd0) $display("FAIL reset_wb_rd got %0d exp 0", wb_rd); else pass_cnt++;
    total_cnt++; if (wb_data !== 32'd0) $display("FAIL reset_wb_data got %h exp 0", wb_data); else pass_cnt++;
    total_cnt++; if (misaligned !== 1'b0) $display("FAIL reset_misaligned got %b exp 0", misaligned); else pass_cnt++;
    total_cnt++; if ({dmem_req, stall} !== 2'b00) $display("FAIL reset_req_stall got %b exp 00", {dmem_req, stall}); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_store();
    // SW 0x1004
    set_inst(1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 5'd0, 32'h0000_1004, 32'hDEAD_BEEF, 1'b1, 32'd0);
    total_cnt++; if (dmem_addr !== 32'h0000_1004) $display("FAIL sw_addr got %h exp 00001004", dmem_addr); else pass_cnt++;
    total_cnt++; if (dmem_be !== 4'b1111) $display("FAIL sw_be got %b exp 1111", dmem_be); else pass_cnt++;
    total_cnt++; if (dmem_wdata !== 32'hDEAD_BEEF) $display("FAIL sw_wdata got %h exp deadbeef", dmem_wdata); else pass_cnt++;
    total_cnt++; if ({dmem_req, dmem_we, stall} !== 3'b110) $display("FAIL sw_req_we_stall got %b exp 110", {dmem_req, dmem_we, stall}); else pass_cnt++;
    after_edge();
    total_cnt++; if (wb_reg_write !== 1'b0) $display("FAIL sw_wb_reg_write got %b exp 0", wb_reg_write); else pass_cnt++;
    // SB 0x1003
    set_inst(1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 5'd0, 32'h0000_1003, 32'h0000_00A5, 1'b1, 32'd0);
    total_cnt++; if (dmem_be !== 4'b1000) $display("FAIL sb_be got %b exp 1000", dmem_be); else pass_cnt++;
    total_cnt++; if (dmem_wdata !== 32'hA5A5_A5A5) $display("FAIL sb_wdata got %h exp a5a5a5a5", dmem_wdata); else pass_cnt++;
    total_cnt++; if (dmem_addr !== 32'h0000_1000) $display("FAIL sb_addr got %h exp 00001000", dmem_addr); else pass_cnt++;
    // SH 0x1002
    set_inst(1'b1, 1'b0, 1'b1, 3'b001, 1'b0, 5'd0, 32'h0000_1002, 32'h0000_1234, 1'b1, 32'd0);
    total_cnt++; if (dmem_be !== 4'b1100) $display("FAIL sh_be got %b exp 1100", dmem_be); else pass_cnt++;
    total_cnt++; if (dmem_wdata !== 32'h1234_1234) $display("FAIL sh_wdata got %h exp 12341234", dmem_wdata); else pass_cnt++;
    // SB lane 1
    set_inst(1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 5'd0, 32'h0000_1001, 32'h0000_003C, 1'b1, 32'd0);
    total_cnt++; if (dmem_be !== 4'b0010) $display("FAIL sb1_be got %b exp 0010", dmem_be); else pass_cnt++;
  endtask

  task automatic test_load();
    // LB 0x2001, rdata 0x00008000
    set_inst(1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 5'd3, 32'h0000_2001, 32'd0, 1'b1, 32'h0000_8000);
    total_cnt++; if (dmem_be !== 4'b1111) $display("FAIL lb_be got %b exp 1111", dmem_be); else pass_cnt++;
    total_cnt++; if ({dmem_req, dmem_we, stall} !== 3'b100) $display("FAIL lb_req_we_stall got %b exp 100", {dmem_req, dmem_we, stall}); else pass_cnt++;
    total_cnt++; if (mem_reg_write !== 1'b0) $display("FAIL lb_mem_reg_write got %b exp 0", mem_reg_write); else pass_cnt++;
    after_edge();
    total_cnt++; if (wb_data !== 32'hFFFF_FF80) $display("FAIL lb_wb_data got %h exp ffffff80", wb_data); else pass_cnt++;
    total_cnt++; if ({wb_reg_write, wb_rd} !== {1'b1, 5'd3}) $display("FAIL lb_wb_ctl got %b/%0d exp 1/3", wb_reg_write, wb_rd); else pass_cnt++;
    // LBU same address
    set_inst(1'b1, 1'b1, 1'b0, 3'b100, 1'b1, 5'd4, 32'h0000_2001, 32'd0, 1'b1, 32'h0000_8000);
    after_edge();
    total_cnt++; if (wb_data !== 32'h0000_0080) $display("FAIL lbu_wb_data got %h exp 00000080", wb_data); else pass_cnt++;
    // LH 0x2002 sign-extended
    set_inst(1'b1, 1'b1, 1'b0, 3'b001, 1'b1, 5'd4, 32'h0000_2002, 32'd0, 1'b1, 32'hF00D_0000);
    after_edge();
    total_cnt++; if (wb_data !== 32'hFFFF_F00D) $display("FAIL lh_wb_data got %h exp fffff00d", wb_data); else pass_cnt++;
    // LHU 0x2002
    set_inst(1'b1, 1'b1, 1'b0, 3'b101, 1'b1, 5'd4, 32'h0000_2002, 32'd0, 1'b1, 32'hF00D_0000);
    after_edge();
    total_cnt++; if (wb_data !== 32'h0000_F00D) $display("FAIL lhu_wb_data got %h exp 0000f00d", wb_data); else pass_cnt++;
  endtask

  task automatic test_wait();
    int stall_cycles;
    stall_cycles = 0;
    // LW 0x4000 with memory not ready for 3 cycles
    for (int i = 0; i < 3; i++) begin
      set_inst(1'b1, 1'b1, 1'b0, 3'b010, 1'b1, 5'd7, 32'h0000_4000, 32'd0, 1'b0, 32'hBAD0_BAD0);
      if (stall === 1'b1) stall_cycles++;
      total_cnt++;
      if ({dmem_req, dmem_addr} !== {1'b1, 32'h0000_4000})
        $display("FAIL wait_req_addr[%0d] got %b/%h exp 1/00004000", i, dmem_req, dmem_addr);
      else pass_cnt++;
      after_edge();
    end
    total_cnt++; if (stall_cycles !== 3) $display("FAIL wait_stall_cycles got %0d exp 3", stall_cycles); else pass_cnt++;
    total_cnt++; if (wb_data !== 32'h0000_F00D) $display("FAIL wait_wb_held got %h exp 0000f00d", wb_data); else pass_cnt++;
    set_inst(1'b1, 1'b1, 1'b0, 3'b010, 1'b1, 5'd7, 32'h0000_4000, 32'd0, 1'b1, 32'h1122_3344);
    total_cnt++; if ({dmem_req, stall} !== 2'b10) $display("FAIL wait_done_req_stall got %b exp 10", {dmem_req, stall}); else pass_cnt++;
    after_edge();
    total_cnt++; if (wb_data !== 32'h1122_3344) $display("FAIL wait_wb_data got %h exp 11223344", wb_data); else pass_cnt++;
    total_cnt++; if ({wb_reg_write, wb_rd} !== {1'b1, 5'd7}) $display("FAIL wait_wb_ctl got %b/%0d exp 1/7", wb_reg_write, wb_rd); else pass_cnt++;
    // back to IDLE: a bubble must not produce a request
    set_inst(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    total_cnt++; if ({dmem_req, stall} !== 2'b00) $display("FAIL wait_idle_req_stall got %b exp 00", {dmem_req, stall}); else pass_cnt++;
  endtask

  task automatic test_misaligned();
    // LW 0x3002: misaligned, no request
    set_inst(1'b1, 1'b1, 1'b0, 3'b010, 1'b1, 5'd9, 32'h0000_3002, 32'd0, 1'b1, 32'h5555_5555);
    total_cnt++; if ({dmem_req, stall} !== 2'b00) $display("FAIL mis_lw_req_stall got %b exp 00", {dmem_req, stall}); else pass_cnt++;
    after_edge();
    total_cnt++; if (misaligned !== 1'b1) $display("FAIL mis_lw_pulse got %b exp 1", misaligned); else pass_cnt++;
    total_cnt++; if (wb_reg_write !== 1'b0) $display("FAIL mis_lw_wb_reg_write got %b exp 0", wb_reg_write); else pass_cnt++;
    set_inst(1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 32'd0);
    after_edge();
    total_cnt++; if (misaligned !== 1'b0) $display("FAIL mis_pulse_end got %b exp 0", misaligned); else pass_cnt++;
    // SH at odd address: misaligned store
    set_inst(1'b1, 1'b0, 1'b1, 3'b001, 1'b0, 5'd0, 32'h0000_3001, 32'h0000_FFFF, 1'b1, 32'd0);
    total_cnt++; if (dmem_req !== 1'b0) $display("FAIL mis_sh_req got %b exp 0", dmem_req); else pass_cnt++;
    after_edge();
    total_cnt++; if (misaligned !== 1'b1) $display("FAIL mis_sh_pulse got %b exp 1", misaligned); else pass_cnt++;
    // illegal funct3 011 on an aligned load
    set_inst(1'b1, 1'b1, 1'b0, 3'b011, 1'b1, 5'd2, 32'h0000_3000, 32'd0, 1'b1, 32'd0);
    total_cnt++; if (dmem_req !== 1'b0) $display("FAIL ill_req got %b exp 0", dmem_req); else pass_cnt++;
    after_edge();
    total_cnt++; if ({misaligned, wb_reg_write} !== 2'b10) $display("FAIL ill_flags got %b exp 10", {misaligned, wb_reg_write}); else pass_cnt++;
  endtask

  task automatic test_alu();
    // ADD rd5 = 7: pass-through, forwarding visible in MEM
    set_inst(1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 5'd5, 32'd7, 32'd0, 1'b1, 32'hFFFF_FFFF);
    total_cnt++; if (mem_forward_value !== 32'd7) $display("FAIL alu_fwd_value got %h exp 7", mem_forward_value); else pass_cnt++;
    total_cnt++; if ({mem_reg_write, mem_rd} !== {1'b1, 5'd5}) $display("FAIL alu_fwd_ctl got %b/%0d exp 1/5", mem_reg_write, mem_rd); else pass_cnt++;
    total_cnt++; if (dmem_req !== 1'b0) $display("FAIL alu_req got %b exp 0", dmem_req); else pass_cnt++;
    after_edge();
    total_cnt++; if (wb_data !== 32'd7) $display("FAIL alu_wb_data got %h exp 7", wb_data); else pass_cnt++;
    total_cnt++; if ({wb_reg_write, wb_rd, misaligned} !== {1'b1, 5'd5, 1'b0}) $display("FAIL alu_wb_ctl got %b/%0d/%b exp 1/5/0", wb_reg_write, wb_rd, misaligned); else pass_cnt++;
    // bubble with ready asserted: ignored, no writeback
    set_inst(1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 5'd6, 32'd9, 32'd0, 1'b1, 32'd0);
    total_cnt++; if ({dmem_req, mem_reg_write} !== 2'b00) $display("FAIL bubble_req_fwd got %b exp 00", {dmem_req, mem_reg_write}); else pass_cnt++;
    after_edge();
    total_cnt++; if (wb_reg_write !== 1'b0) $display("FAIL bubble_wb_reg_write got %b exp 0", wb_reg_write); else pass_cnt++;
  endtask

  task automatic test_reset_in_wait();
    set_inst(1'b1, 1'b1, 1'b0, 3'b010, 1'b1, 5'd11, 32'h0000_5000, 32'd0, 1'b0, 32'd0);
    after_edge();
    @(negedge clk);
    #1;
    total_cnt++; if ({dmem_req, stall} !== 2'b11) $display("FAIL rstw_pre got %b exp 11", {dmem_req, stall}); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if ({dmem_req, stall, dmem_we} !== 3'b000) $display("FAIL rstw_drop got %b exp 000", {dmem_req, stall, dmem_we}); else pass_cnt++;
    ex_valid = 1'b0;
    mem_read = 1'b0;
    dmem_ready = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    after_edge();
    @(negedge clk);
    rst = 1'b0;
    dmem_ready = 1'b0;
    #1;
    total_cnt++; if ({dmem_req, stall} !== 2'b00) $display("FAIL rstw_idle got %b exp 00", {dmem_req, stall}); else pass_cnt++;
    after_edge();
    total_cnt++; if ({wb_reg_write, wb_data} !== {1'b0, 32'h0000_5000}) $display("FAIL rstw_wb got %b/%h exp 0/00005000", wb_reg_write, wb_data); else pass_cnt++;
    // a fresh zero-wait access goes through normally
    set_inst(1'b1, 1'b1, 1'b0, 3'b010, 1'b1, 5'd12, 32'h0000_6000, 32'd0, 1'b1, 32'h0BAD_CAFE);
    after_edge();
    total_cnt++; if ({wb_reg_write, wb_rd, wb_data} !== {1'b1, 5'd12, 32'h0BAD_CAFE}) $display("FAIL rstw_after got %b/%0d/%h exp 1/12/0badcafe", wb_reg_write, wb_rd, wb_data); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_wait();
    test_misaligned();
    test_alu();
    test_reset_in_wait();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage RV32I pipeline. Takes the EX/MEM register contents (ALU result as address or result, forwarded store data, control bits) and issues loads and stores to the data memory over a req/ready handshake. It also aligns byte lanes and sign- or zero-extends load data, stalls the pipeline while memory is busy, and registers the MEM/WB result. It is the source of the MEM-stage forwarding value and the MEM/WB values that the execute stage consumes.

## Interface
Parameters:
- none. Data and address widths are fixed at 32.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- ex_valid  in  1  EX/MEM register holds a live instruction
- mem_read  in  1  instruction is a load
- mem_write  in  1  instruction is a store
- funct3  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- reg_write  in  1  instruction writes rd
- rd  in  5  destination register
- alu_result  in  32  effective address, or the result for non-memory ops
- write_data  in  32  store data, already forwarded
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word address {alu_result[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ready  in  1  memory accepts/completes the request this cycle
- dmem_rdata  in  32  load word, valid when dmem_ready=1 and dmem_we=0
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- misaligned  out  1  registered one-cycle exception pulse
- mem_reg_write  out  1  ex_valid & reg_write & ~mem_read (feeds forwarding)
- mem_rd  out  5  = rd
- mem_forward_value  out  32  = alu_result
- wb_reg_write  out  1  registered
- wb_rd  out  5  registered
- wb_data  out  32  registered load data or alu_result

## Operation
- Access: acc = ex_valid & (mem_read | mem_write). A misaligned or illegal access never issues dmem_req.
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]≠0. Illegal: funct3 ∈ {011,110,111}.
- FSM states:
  - IDLE: dmem_req = acc & ~bad. If dmem_ready is also high, the access completes this cycle. Otherwise go to WAIT.
  - WAIT: dmem_req=1 and stall=1. Go to IDLE on the cycle dmem_ready=1, which is the completion cycle.
- Inputs stay stable while stall=1, because upstream is frozen.
- Stall: stall = dmem_req & ~dmem_ready, combinational.
- Stores:
  - B: be = 4'b0001<<addr[1:0], wdata = {4{wd[7:0]}}
  - H: be = addr[1] ? 1100 : 0011, wdata = {2{wd[15:0]}}
  - W: be = 1111, wdata = wd
  - For loads, be=1111.
- Loads: select the lane by addr[1:0]. B/H sign-extend; BU/HU zero-extend.
- MEM/WB register updates when stall=0:
  - wb_reg_write = ex_valid & reg_write & ~bad
  - wb_rd = rd
  - wb_data = load ? extended rdata : alu_result
  - Bubble (ex_valid=0): wb_reg_write=0.
- misaligned is registered high for one cycle after a bad access with ex_valid=1; that access has wb_reg_write=0.
- Load-use forwarding: mem_reg_write excludes loads. The hazard unit inserts the load-use bubble, so no forwarding from MEM occurs for loads.

## Timing
- Reset (async): FSM to IDLE; wb_reg_write=0, wb_rd=0, wb_data=0, misaligned=0. dmem_req and stall fall immediately with rst.
- Zero-wait access: request and completion happen in the same cycle; the wb_* values appear after the next edge. Latency is 1 cycle, the same as a non-memory op.
- N-cycle wait: stall is high for N cycles; the wb_* update is on the edge after dmem_ready.
- Reset while in WAIT: the request is abandoned and the write is lost; no wb update.
- rst deasserting with ex_valid high: a normal access starts in that cycle.
- dmem_ready with dmem_req=0 is ignored.

## Test plan
- SW with alu_result=0x1004, wd=0xDEADBEEF, dmem_ready=1 -> addr 0x1004, be 1111, wdata 0xDEADBEEF, stall 0, wb_reg_write 0.
- SB with addr 0x1003, wd=0x000000A5 -> be 1000, wdata 0xA5A5A5A5. SH with addr 0x1002 -> be 1100.
- LB at 0x2001 with rdata 0x0000_8000 -> wb_data 0xFFFFFF80. LBU -> 0x00000080. LHU at 0x2002 with rdata 0xF00D0000 -> 0x0000F00D.
- LW with dmem_ready low for 3 cycles -> stall high for exactly 3 cycles, dmem_req held with a stable addr, wb_data=rdata one edge after ready.
- LW at 0x3002 -> no dmem_req, misaligned pulses for 1 cycle, wb_reg_write 0. ADD with alu_result 7, rd 5 -> mem_forward_value 7, mem_reg_write 1, next cycle wb_data 7, wb_rd 5.
- rst asserted in WAIT -> dmem_req and stall drop immediately; after release, wb_reg_write=0 and the FSM is in IDLE.
